// File: rtl/main_memory.sv
// main_memory: behavioural single-beat memory responder for the cache bus.
// Accepts one request at a time; writes land at the accept edge with no
// response, and reads return one beat after a fixed latency.
// Optional build macro MAIN_MEMORY_RAND_STALL_EN adds an LFSR-driven 0-3
// cycle stall to every request.
module main_memory #(
  parameter int unsigned dma_data_width_p = 4,
  parameter int unsigned mem_words_p      = 1024,
  parameter int unsigned latency_p        = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            mem_valid_i,
  output logic                            mem_ready_o,
  input  logic                            mem_we_i,
  input  logic [31:0]                     mem_addr_i,
  input  logic [32*dma_data_width_p-1:0]  mem_wdata_i,
  output logic                            mem_valid_o,
  output logic [32*dma_data_width_p-1:0]  mem_data_o
);

  localparam int unsigned BW  = 32 * dma_data_width_p;
  localparam int unsigned IW  = $clog2(mem_words_p);
  localparam int unsigned LSB = $clog2(4 * dma_data_width_p);
  localparam int unsigned CW  = $clog2(latency_p + 3) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_we;
  logic [IW-1:0]    r_idx;
  logic             r_valid;
  logic [BW-1:0]    r_data;
  logic [BW-1:0]    r_mem [mem_words_p];

  logic             w_accept;
  logic [IW-1:0]    w_idx;
  logic [CW-1:0]    w_stall;
  logic [CW-1:0]    w_load;
  logic             w_unused;

  assign mem_ready_o = (r_state == S_IDLE) & ~reset_i;
  assign w_accept    = mem_valid_i & mem_ready_o;
  assign w_idx       = mem_addr_i[LSB +: IW];
  assign w_load      = CW'(latency_p - 1) + w_stall;
  assign mem_valid_o = r_valid;
  assign mem_data_o  = r_data;
  // Byte-offset and alias bits of the address are intentionally ignored.
  assign w_unused    = ^mem_addr_i;

`ifdef MAIN_MEMORY_RAND_STALL_EN
  logic [7:0] r_lfsr;

  // Stall uses the LFSR value before it advances on this accept.
  assign w_stall = CW'(r_lfsr[1:0]);

  // Fibonacci LFSR (taps 8,6,5,4) stepping once per accepted request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end
`else
  assign w_stall = '0;
`endif

  // Storage array: writes land at the accept edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_accept && mem_we_i) begin
      r_mem[w_idx] <= mem_wdata_i;
    end
  end

  // Request FSM: latch request, count latency, emit registered read strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we  <= mem_we_i;
            r_idx <= w_idx;
            r_cnt <= w_load;
            if (w_load == '0) begin
              // Strobe and data are registered on entry so RESP is the
              // cycle that drives them.
              r_state <= S_RESP;
              r_valid <= ~mem_we_i;
              if (!mem_we_i) begin
                r_data <= r_mem[w_idx];
              end
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt <= CW'(1)) begin
            r_cnt   <= '0;
            r_state <= S_RESP;
            r_valid <= ~r_we;
            if (!r_we) begin
              r_data <= r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: randomized traffic against a cycle-level
// behavioural model, plus directed scenarios with hand-computed timing.
module tb_main_memory;

  localparam int unsigned BW  = 128;
  localparam int unsigned LAT = 4;
`ifdef MAIN_MEMORY_RAND_STALL_EN
  localparam int unsigned WR_RDY_K = 6;
  localparam int unsigned RD_ACC_K = 6;
  localparam int unsigned RESP_K   = 12;
  localparam int unsigned L1_WS    = 1;
  localparam int unsigned L1_RS    = 2;
`else
  localparam int unsigned WR_RDY_K = 5;
  localparam int unsigned RD_ACC_K = 5;
  localparam int unsigned RESP_K   = 9;
  localparam int unsigned L1_WS    = 0;
  localparam int unsigned L1_RS    = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          mem_valid_i = 1'b0;
  logic          mem_we_i = 1'b0;
  logic [31:0]   mem_addr_i = '0;
  logic [BW-1:0] mem_wdata_i = '0;
  logic          mem_ready_o;
  logic          mem_valid_o;
  logic [BW-1:0] mem_data_o;

  logic          v1 = 1'b0;
  logic          we1 = 1'b0;
  logic [31:0]   a1 = '0;
  logic [BW-1:0] d1 = '0;
  logic          rdy1;
  logic          val1;
  logic [BW-1:0] dat1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  main_memory u_dut (
    .clk_i(clk), .reset_i(reset_i), .mem_valid_i(mem_valid_i),
    .mem_ready_o(mem_ready_o), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_valid_o(mem_valid_o), .mem_data_o(mem_data_o)
  );

  main_memory #(.latency_p(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .mem_valid_i(v1),
    .mem_ready_o(rdy1), .mem_we_i(we1), .mem_addr_i(a1),
    .mem_wdata_i(d1), .mem_valid_o(val1), .mem_data_o(dat1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [BW-1:0] mem_model [1024];
  bit            model_on = 0;
  bit            m_pend = 0;
  bit            m_read = 0;
  int unsigned   m_resp_at = 0;
  int unsigned   m_ready_at = 0;
  logic [BW-1:0] m_pdata = '0;
  logic [BW-1:0] m_last = '0;
  logic [7:0]    m_lfsr = 8'hA5;

  always @(negedge clk) begin
    bit          er;
    bit          ev;
    int unsigned lat;
    int unsigned idx;
    er = 0;
    if (model_on) begin
      er = !reset_i && (cyc >= m_ready_at);
      ev = m_pend && m_read && (cyc == m_resp_at);
      if (ev) m_last = m_pdata;
      chk("model_ready", 128'(mem_ready_o), 128'(er));
      chk("model_valid", 128'(mem_valid_o), 128'(ev));
      chk("model_data", mem_data_o, m_last);
    end
    if (reset_i) begin
      m_pend     = 0;
      m_ready_at = cyc + 1;
      m_last     = '0;
      m_lfsr     = 8'hA5;
      model_on   = 1;
    end else if (model_on && mem_valid_i && er) begin
      lat = LAT;
`ifdef MAIN_MEMORY_RAND_STALL_EN
      lat = lat + (m_lfsr % 4);
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
      idx        = (mem_addr_i >> 4) % 1024;
      m_pend     = 1;
      m_read     = !mem_we_i;
      m_resp_at  = cyc + lat;
      m_ready_at = cyc + lat + 1;
      if (mem_we_i) mem_model[idx] = mem_wdata_i;
      else          m_pdata = mem_model[idx];
    end
  end

  // ---------------- driver helpers ----------------
  task automatic do_req(input logic we, input logic [31:0] a, input logic [BW-1:0] d,
                        output int unsigned t);
    bit done;
    done = 0;
    t = 0;
    for (int unsigned i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      mem_valid_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_wdata_i = d;
      @(negedge clk);
      if (mem_ready_o) begin
        done = 1;
        t = cyc;
      end
    end
    chk("req_accepted", 128'(done), 128'(1));
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
  endtask

  task automatic wait_resp(output logic [BW-1:0] d, output bit ok);
    ok = 0;
    d  = '0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_valid_o) begin
        d  = mem_data_o;
        ok = 1;
        break;
      end
    end
  endtask

  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int unsigned   t;
    int unsigned   n;
    int unsigned   acc_k;
    int unsigned   pulses;
    int unsigned   acc [3];
    bit            rd_done;
    bit            ok;
    logic [BW-1:0] rd;
    logic [BW-1:0] wv;
    logic [BW-1:0] av;
    logic [BW-1:0] rv;
    logic [BW-1:0] k1;
    logic [31:0]   glist [3];

    glist = '{32'h0, 32'h10, 32'h20};
    wv = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready_low", 128'(mem_ready_o), 128'(0));
    chk("reset_valid_low", 128'(mem_valid_o), 128'(0));
    chk("reset_data_zero", mem_data_o, '0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 128'(mem_ready_o), 128'(1));

    // Write 0x40 at T, then keep a read of 0x40 pending until accepted.
    @(posedge clk); #1;
    mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h40; mem_wdata_i = wv;
    @(negedge clk);
    chk("wr_accept_ready", 128'(mem_ready_o), 128'(1));
    rd_done = 0;
    acc_k = 0;
    for (int unsigned k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (rd_done) begin
        mem_valid_i = 1'b0;
      end else begin
        mem_valid_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40; mem_wdata_i = rnd_beat();
      end
      @(negedge clk);
      if (k <= WR_RDY_K) chk("wr_ready_window", 128'(mem_ready_o), 128'(k == WR_RDY_K));
      chk("rd_strobe_cycle", 128'(mem_valid_o), 128'(k == RESP_K));
      if (k == RESP_K) chk("rd_after_wr_data", mem_data_o, wv);
      if (mem_valid_i && mem_ready_o && !rd_done) begin
        rd_done = 1;
        acc_k = k;
      end
    end
    chk("rd_accept_cycle", 128'(acc_k), 128'(RD_ACC_K));

    // latency_p=1 instance: write then read of 0x30.
    k1 = rnd_beat();
    @(posedge clk); #1;
    v1 = 1'b1; we1 = 1'b1; a1 = 32'h30; d1 = k1;
    @(negedge clk);
    chk("l1_wr_ready", 128'(rdy1), 128'(1));
    @(posedge clk); #1;
    v1 = 1'b0;
    n = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      n++;
      chk("l1_wr_no_strobe", 128'(val1), 128'(0));
      if (rdy1) break;
    end
    chk("l1_wr_ready_back", 128'(n), 128'(2 + L1_WS));
    @(posedge clk); #1;
    v1 = 1'b1; we1 = 1'b0; a1 = 32'h30;
    @(negedge clk);
    chk("l1_rd_ready", 128'(rdy1), 128'(1));
    for (int unsigned k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      v1 = 1'b0;
      @(negedge clk);
      chk("l1_rd_strobe", 128'(val1), 128'(k == 1 + L1_RS));
      if (k == 1 + L1_RS) chk("l1_rd_data", dat1, k1);
      chk("l1_rd_ready_again", 128'(rdy1), 128'(k >= 2 + L1_RS));
    end

    // Populate indices 0..31 so random reads hit known data.
    for (int unsigned i = 0; i < 32; i++) begin
      do_req(1'b1, (i << 4) | ($urandom & 32'hF), rnd_beat(), t);
    end

    // Continuous valid with three reads.
    n = 0;
    for (int unsigned i = 0; i < 40 && n < 3; i++) begin
      @(posedge clk); #1;
      mem_valid_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = glist[n];
      @(negedge clk);
      if (mem_ready_o) begin
        acc[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    chk("gate_accepts", 128'(n), 128'(3));
`ifndef MAIN_MEMORY_RAND_STALL_EN
    chk("gate_gap_1", 128'(acc[1] - acc[0]), 128'(5));
    chk("gate_gap_2", 128'(acc[2] - acc[1]), 128'(5));
`endif

    // Aliasing and byte-offset: 0x10 and 0x401C share an index.
    av = rnd_beat();
    do_req(1'b1, 32'h0000_0010, av, t);
    do_req(1'b0, 32'h0000_401C, '0, t);
    wait_resp(rd, ok);
    chk("alias_resp_seen", 128'(ok), 128'(1));
    chk("alias_data", rd, av);

    // Reset two cycles after a read accept.
    rv = rnd_beat();
    do_req(1'b1, 32'h70, rv, t);
    do_req(1'b0, 32'h70, '0, t);
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", 128'(mem_ready_o), 128'(1));
    pulses = 32'(mem_valid_o);
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      pulses += 32'(mem_valid_o);
    end
    chk("rst_no_pulse", 128'(pulses), 128'(0));
    do_req(1'b0, 32'h70, '0, t);
    wait_resp(rd, ok);
    chk("rst_resp_seen", 128'(ok), 128'(1));
    chk("rst_preserved_data", rd, rv);

    // Randomized traffic; inputs change every cycle whether or not ready.
    for (int unsigned i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      reset_i     = ($urandom_range(0, 99) == 0);
      mem_valid_i = ($urandom_range(0, 1) == 1);
      mem_we_i    = ($urandom_range(0, 2) == 0);
      mem_addr_i  = ($urandom & 32'hFFFF_C00F) | (32'($urandom_range(0, 31)) << 4);
      mem_wdata_i = rnd_beat();
    end
    @(posedge clk); #1;
    reset_i = 1'b0;
    mem_valid_i = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/main_memory.md
# main_memory

Behavioural main-memory responder at the memory end of the cache bus. It accepts one single-beat request at a time over the bus's `mem_valid`/`mem_ready` handshake. Writes are stored with no response. Reads return one beat of `32*dma_data_width_p` bits after a fixed latency. It is the memory model in single- and multi-core simulation benches.

## Interface
- `dma_data_width_p`, default 4: words (32 bits) per beat; beat width is `32*dma_data_width_p` bits, matching `DMA_DATA_WIDTH`.
- `mem_words_p`, default 1024: depth in beats; power of 2, ≥2.
- `latency_p`, default 4: cycles from request acceptance to read response; ≥1.

Ports:
- `clk_i`, input, 1: clock; all state updates on its rising edge.
- `reset_i`, input, 1: reset; synchronous, active-high.
- `mem_valid_i`, input, 1: request valid from bus.
- `mem_ready_o`, output, 1: responder can accept a request this cycle.
- `mem_we_i`, input, 1: 1 = write, 0 = read.
- `mem_addr_i`, input, 32: byte address.
- `mem_wdata_i`, input, `32*dma_data_width_p`: write beat.
- `mem_valid_o`, output, 1: one-cycle read-response strobe.
- `mem_data_o`, output, `32*dma_data_width_p`: read beat; valid while `mem_valid_o`=1.

## Operation
- State machine states:
  - IDLE: accepting.
  - WAIT: counting latency.
  - RESP: read response cycle.
- Accept: a request is accepted at a rising edge where `mem_valid_i & mem_ready_o`.
- Ready:
  - `mem_ready_o = (state==IDLE) & ~reset_i`.
  - Ready is never a function of `mem_valid_i`; the bus derives its yumi combinationally from it.
- Beat index: `mem_addr_i[lsb +: log2(mem_words_p)]`, where `lsb = log2(4*dma_data_width_p)`.
  - Low byte-offset bits are ignored.
  - Upper bits are ignored, so addresses alias modulo `mem_words_p` beats.
- IDLE transitions:
  - On accept, latch `we` and the index, and load counter = `latency_p-1` (+ stall, see Configuration).
  - If counter = 0, go to RESP; otherwise go to WAIT.
  - For a write, the array entry is written at the accept edge.
- WAIT: decrement counter each cycle; go to RESP in the cycle after the counter reaches 0.
- RESP:
  - Read: `mem_valid_o`=1 for exactly one cycle; `mem_data_o` = array[latched index].
  - Write: `mem_valid_o` stays 0.
  - Next state is always IDLE.
- `mem_data_o` holds its last read value outside RESP. It does not change on writes.
- Inputs other than `mem_valid_i` are ignored when not accepting.
- Read-after-write to the same index returns the written beat. This holds even back to back, because the write lands at its accept edge.

## Timing
- Accept at edge T (with zero stall):
  - `mem_ready_o`=0 from cycle T+1 through T+`latency_p`.
  - RESP occupies cycle T+`latency_p`; the read strobe is high in that cycle.
  - `mem_ready_o`=1 again at T+`latency_p`+1.
- Throughput: one request per `latency_p+1` cycles.
- Reset values:
  - state = IDLE, `mem_valid_o`=0, `mem_data_o`=0, counter = 0.
  - `mem_ready_o`=0 while `reset_i`=1 and 1 on the first cycle after.
- Reset mid-operation: any pending read is dropped and no `mem_valid_o` pulse occurs. Array contents are preserved; a write already accepted stays written.
- Memory contents are not initialised; an unwritten read returns X.

## Configuration
- `MAIN_MEMORY_RAND_STALL_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset value 8'hA5) advances once per accept.
  - At accept, the counter loads `latency_p-1 + lfsr[1:0]`, using the pre-advance LFSR value.
  - This adds 0–3 extra cycles before RESP and in the `mem_ready_o`-low window.
- Macro undefined:
  - No LFSR exists.
  - Latency is exactly `latency_p` for every request.

## Test plan
- Write then read (defaults):
  - Write addr 0x40, wdata 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C, accepted at T.
  - Read of 0x40 is accepted at T+5.
  - Required: `mem_valid_o` high only in cycle T+9, `mem_data_o` = written value; no strobe for the write.
- Ready gating:
  - Hold `mem_valid_i`=1 continuously with reads to 0x0, 0x10, 0x20.
  - Required: accepts exactly every 5 cycles; `mem_ready_o` low 4 cycles after each accept.
- Aliasing and offset:
  - Write 0x0000_0010, then read 0x0000_401C (same index with `mem_words_p`=1024).
  - Required: the read returns the written beat.
- Reset mid-read:
  - Accept a read at T and assert `reset_i` in cycle T+2.
  - Required: no `mem_valid_o` pulse; `mem_ready_o` is 1 in the cycle after reset deasserts; a prior write to that index still reads back intact.
- `latency_p`=1:
  - Accept a read at T.
  - Required: `mem_valid_o` at T+1, ready again at T+2.
- With `MAIN_MEMORY_RAND_STALL_EN`:
  - First accept after reset (LFSR 8'hA5, lfsr[1:0]=1).
  - Required: strobe at T+5; `mem_ready_o` low for 5 cycles.
